// File: rtl/axi_pkg.sv
// Shared AXI read-arbiter types: arbiter FSM states plus AXI burst and response encodings.
package axi_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } arb_state_t;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [1:0] OKAY   = 2'd0;
  localparam logic [1:0] EXOKAY = 2'd1;
  localparam logic [1:0] SLVERR = 2'd2;
  localparam logic [1:0] DECERR = 2'd3;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin tie breaker: a lone requester always wins, prio picks the winner of a tie.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       prio,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = req;
    if (req == 2'b11) gnt = prio ? 2'b10 : 2'b01;
  end

endmodule

// File: rtl/axi_rd_arbiter.sv
// Shares one AXI read channel between the I$ (s0) and D$ (s1) line-fill ports, one burst at a time.
// Optional perf counters are compiled in with AXI_RD_ARB_PERF_EN.
module axi_rd_arbiter
  import axi_pkg::*;
#(
  parameter int ID_WIDTH   = 13,
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ID_WIDTH-1:0]   s0_arid,
  input  logic [ADDR_WIDTH-1:0] s0_araddr,
  input  logic [7:0]            s0_arlen,
  input  logic [2:0]            s0_arsize,
  input  logic [1:0]            s0_arburst,
  input  logic                  s0_arvalid,
  output logic                  s0_arready,
  output logic [ID_WIDTH-1:0]   s0_rid,
  output logic [DATA_WIDTH-1:0] s0_rdata,
  output logic [1:0]            s0_rresp,
  output logic                  s0_rlast,
  output logic                  s0_rvalid,
  input  logic                  s0_rready,
  input  logic [ID_WIDTH-1:0]   s1_arid,
  input  logic [ADDR_WIDTH-1:0] s1_araddr,
  input  logic [7:0]            s1_arlen,
  input  logic [2:0]            s1_arsize,
  input  logic [1:0]            s1_arburst,
  input  logic                  s1_arvalid,
  output logic                  s1_arready,
  output logic [ID_WIDTH-1:0]   s1_rid,
  output logic [DATA_WIDTH-1:0] s1_rdata,
  output logic [1:0]            s1_rresp,
  output logic                  s1_rlast,
  output logic                  s1_rvalid,
  input  logic                  s1_rready,
  output logic [ID_WIDTH-1:0]   m_axi_arid,
  output logic [ADDR_WIDTH-1:0] m_axi_araddr,
  output logic [7:0]            m_axi_arlen,
  output logic [2:0]            m_axi_arsize,
  output logic [1:0]            m_axi_arburst,
  output logic                  m_axi_arlock,
  output logic [3:0]            m_axi_arcache,
  output logic [2:0]            m_axi_arprot,
  output logic                  m_axi_arvalid,
  input  logic                  m_axi_arready,
  input  logic [ID_WIDTH-1:0]   m_axi_rid,
  input  logic [DATA_WIDTH-1:0] m_axi_rdata,
  input  logic [1:0]            m_axi_rresp,
  input  logic                  m_axi_rlast,
  input  logic                  m_axi_rvalid,
  output logic                  m_axi_rready
`ifdef AXI_RD_ARB_PERF_EN
  ,
  output logic [31:0]           perf_grant0,
  output logic [31:0]           perf_grant1,
  output logic [31:0]           perf_wait
`endif
);

  arb_state_t state, state_nxt;
  logic       owner, owner_nxt;
  logic       prio, prio_nxt;
  logic [1:0] gnt;
  logic       r_done;

  rr_arb2 u_rr_arb2 (
    .req  ({s1_arvalid, s0_arvalid}),
    .prio (prio),
    .gnt  (gnt)
  );

  assign r_done = m_axi_rvalid & m_axi_rready & m_axi_rlast;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      owner <= 1'b0;
      prio  <= 1'b0;
    end else begin
      state <= state_nxt;
      owner <= owner_nxt;
      prio  <= prio_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    owner_nxt = owner;
    prio_nxt  = prio;
    unique case (state)
      IDLE: if (|gnt) begin
        owner_nxt = gnt[1];
        state_nxt = ADDR;
      end
      ADDR: if (m_axi_arready) state_nxt = DATA;
      DATA: if (r_done) begin
        state_nxt = IDLE;
        prio_nxt  = ~owner;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Handshake steering: only the owner ever sees a ready/valid from downstream.
  always_comb begin
    m_axi_arvalid = 1'b0;
    m_axi_rready  = 1'b0;
    s0_arready    = 1'b0;
    s1_arready    = 1'b0;
    s0_rvalid     = 1'b0;
    s1_rvalid     = 1'b0;
    unique case (state)
      ADDR: begin
        m_axi_arvalid = 1'b1;
        s0_arready    = ~owner & m_axi_arready;
        s1_arready    =  owner & m_axi_arready;
      end
      DATA: begin
        m_axi_rready = owner ? s1_rready : s0_rready;
        s0_rvalid    = ~owner & m_axi_rvalid;
        s1_rvalid    =  owner & m_axi_rvalid;
      end
      default: ;
    endcase
  end

  assign m_axi_arid    = owner ? s1_arid    : s0_arid;
  assign m_axi_araddr  = owner ? s1_araddr  : s0_araddr;
  assign m_axi_arlen   = owner ? s1_arlen   : s0_arlen;
  assign m_axi_arsize  = owner ? s1_arsize  : s0_arsize;
  assign m_axi_arburst = owner ? s1_arburst : s0_arburst;
  assign m_axi_arlock  = 1'b0;
  assign m_axi_arcache = 4'd0;
  assign m_axi_arprot  = 3'd0;

  assign s0_rid   = m_axi_rid;
  assign s0_rdata = m_axi_rdata;
  assign s0_rresp = m_axi_rresp;
  assign s0_rlast = m_axi_rlast;
  assign s1_rid   = m_axi_rid;
  assign s1_rdata = m_axi_rdata;
  assign s1_rresp = m_axi_rresp;
  assign s1_rlast = m_axi_rlast;

`ifdef AXI_RD_ARB_PERF_EN
  // Counters wrap naturally at 2^32.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_grant0 <= 32'd0;
      perf_grant1 <= 32'd0;
      perf_wait   <= 32'd0;
    end else begin
      if (s0_arvalid & s0_arready) perf_grant0 <= perf_grant0 + 32'd1;
      if (s1_arvalid & s1_arready) perf_grant1 <= perf_grant1 + 32'd1;
      if ((s0_arvalid & ~s0_arready) | (s1_arvalid & ~s1_arready))
        perf_wait <= perf_wait + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Scoreboard bench for axi_rd_arbiter: expected AR/R traffic is queued by the stimulus and checked by a monitor.
module tb_axi_rd_arbiter;
  import axi_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [12:0] s0_arid, s1_arid;
  logic [63:0] s0_araddr, s1_araddr;
  logic [7:0]  s0_arlen, s1_arlen;
  logic [2:0]  s0_arsize, s1_arsize;
  logic [1:0]  s0_arburst, s1_arburst;
  logic        s0_arvalid, s1_arvalid, s0_arready, s1_arready;
  logic [12:0] s0_rid, s1_rid;
  logic [63:0] s0_rdata, s1_rdata;
  logic [1:0]  s0_rresp, s1_rresp;
  logic        s0_rlast, s1_rlast, s0_rvalid, s1_rvalid, s0_rready, s1_rready;
  logic [12:0] m_axi_arid;
  logic [63:0] m_axi_araddr;
  logic [7:0]  m_axi_arlen;
  logic [2:0]  m_axi_arsize;
  logic [1:0]  m_axi_arburst;
  logic        m_axi_arlock;
  logic [3:0]  m_axi_arcache;
  logic [2:0]  m_axi_arprot;
  logic        m_axi_arvalid, m_axi_arready;
  logic [12:0] m_axi_rid;
  logic [63:0] m_axi_rdata;
  logic [1:0]  m_axi_rresp;
  logic        m_axi_rlast, m_axi_rvalid, m_axi_rready;

  axi_rd_arbiter dut (
    .clk(clk), .reset(reset),
    .s0_arid(s0_arid), .s0_araddr(s0_araddr), .s0_arlen(s0_arlen), .s0_arsize(s0_arsize),
    .s0_arburst(s0_arburst), .s0_arvalid(s0_arvalid), .s0_arready(s0_arready),
    .s0_rid(s0_rid), .s0_rdata(s0_rdata), .s0_rresp(s0_rresp), .s0_rlast(s0_rlast),
    .s0_rvalid(s0_rvalid), .s0_rready(s0_rready),
    .s1_arid(s1_arid), .s1_araddr(s1_araddr), .s1_arlen(s1_arlen), .s1_arsize(s1_arsize),
    .s1_arburst(s1_arburst), .s1_arvalid(s1_arvalid), .s1_arready(s1_arready),
    .s1_rid(s1_rid), .s1_rdata(s1_rdata), .s1_rresp(s1_rresp), .s1_rlast(s1_rlast),
    .s1_rvalid(s1_rvalid), .s1_rready(s1_rready),
    .m_axi_arid(m_axi_arid), .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen),
    .m_axi_arsize(m_axi_arsize), .m_axi_arburst(m_axi_arburst), .m_axi_arlock(m_axi_arlock),
    .m_axi_arcache(m_axi_arcache), .m_axi_arprot(m_axi_arprot),
    .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_rid(m_axi_rid), .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
    .m_axi_rlast(m_axi_rlast), .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [63:0] addr;
    logic [7:0]  len;
    logic [12:0] id;
    logic [1:0]  burst;
  } ar_exp_t;

  typedef struct packed {
    logic        own;
    logic [63:0] data;
    logic [12:0] id;
    logic [1:0]  resp;
    logic        last;
  } r_exp_t;

  ar_exp_t ar_q[$];
  r_exp_t  r_q[$];
  int total = 0;
  int bad = 0;
  int cyc = 0;
  int rx_cnt = 0;
  int rxb = 0;
  int last_rlast_cyc = 0;
  int last_gap = -1;
  logic prev_arvalid = 1'b0;
  logic [1:0] slv_resp = OKAY;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  task automatic expect_txn(input logic own, input logic [63:0] addr, input logic [7:0] len,
                            input logic [12:0] id, input logic [1:0] burst, input logic [1:0] resp);
    ar_q.push_back('{addr, len, id, burst});
    for (int i = 0; i <= int'(len); i++)
      r_q.push_back('{own, addr + 64'(i), id, resp, (i == int'(len))});
  endtask

  task automatic issue(input int k, input logic [63:0] addr, input logic [7:0] len, input logic [12:0] id);
    int n;
    logic rdy;
    n = 0;
    if (k == 0) begin
      s0_araddr = addr; s0_arlen = len; s0_arid = id; s0_arvalid = 1'b1;
    end else begin
      s1_araddr = addr; s1_arlen = len; s1_arid = id; s1_arvalid = 1'b1;
    end
    forever begin
      @(negedge clk);
      rdy = (k == 0) ? s0_arready : s1_arready;
      if (rdy) break;
      n++;
      if (n > 200) begin
        chk("ar_timeout", 64'd0, 64'd1);
        break;
      end
    end
    @(posedge clk); #1;
    if (k == 0) s0_arvalid = 1'b0; else s1_arvalid = 1'b0;
  endtask

  task automatic wait_rx(input int target);
    int n;
    n = 0;
    forever begin
      @(negedge clk); #1;
      if (rx_cnt >= target) break;
      n++;
      if (n > 500) begin
        chk("rx_timeout", 64'(rx_cnt), 64'(target));
        break;
      end
    end
  endtask

  task automatic chk_quiet(input string nm);
    chk({nm, "_m_arvalid"}, 64'(m_axi_arvalid), 64'd0);
    chk({nm, "_m_rready"},  64'(m_axi_rready),  64'd0);
    chk({nm, "_s0_arready"}, 64'(s0_arready), 64'd0);
    chk({nm, "_s1_arready"}, 64'(s1_arready), 64'd0);
    chk({nm, "_s0_rvalid"},  64'(s0_rvalid),  64'd0);
    chk({nm, "_s1_rvalid"},  64'(s1_rvalid),  64'd0);
  endtask

  always @(posedge clk) cyc++;

  // Monitor: pops the scoreboard whenever the DUT completes an AR or R handshake.
  always @(negedge clk) begin
    ar_exp_t a;
    r_exp_t  e;
    if (m_axi_arvalid && !prev_arvalid) last_gap = cyc - last_rlast_cyc;
    prev_arvalid = m_axi_arvalid;
    if (m_axi_arvalid && m_axi_arready) begin
      if (ar_q.size() == 0) chk("ar_unexpected", 64'd1, 64'd0);
      else begin
        a = ar_q.pop_front();
        chk("ar_addr", m_axi_araddr, a.addr);
        chk("ar_len", 64'(m_axi_arlen), 64'(a.len));
        chk("ar_id", 64'(m_axi_arid), 64'(a.id));
        chk("ar_burst", 64'(m_axi_arburst), 64'(a.burst));
        chk("ar_const", 64'({m_axi_arlock, m_axi_arcache, m_axi_arprot}), 64'd0);
      end
    end
    if (s0_rvalid && s1_rvalid) chk("r_both_valid", 64'd1, 64'd0);
    if ((s0_rvalid && s0_rready) || (s1_rvalid && s1_rready)) begin
      if (r_q.size() == 0) chk("r_unexpected", 64'd1, 64'd0);
      else begin
        e = r_q.pop_front();
        chk("r_owner", 64'(s1_rvalid), 64'(e.own));
        chk("r_data", s1_rvalid ? s1_rdata : s0_rdata, e.data);
        chk("r_id", 64'(s1_rvalid ? s1_rid : s0_rid), 64'(e.id));
        chk("r_resp", 64'(s1_rvalid ? s1_rresp : s0_rresp), 64'(e.resp));
        chk("r_last", 64'(s1_rvalid ? s1_rlast : s0_rlast), 64'(e.last));
        rx_cnt++;
        if (e.last) last_rlast_cyc = cyc;
      end
    end
  end

  // Downstream slave: one outstanding burst, data = araddr + beat index.
  initial begin
    logic ar_hs, r_hs;
    logic [63:0] base;
    logic [7:0] len, beat;
    logic [12:0] id;
    base = 64'd0; len = 8'd0; beat = 8'd0; id = 13'd0;
    m_axi_arready = 1'b1;
    m_axi_rvalid = 1'b0; m_axi_rlast = 1'b0; m_axi_rdata = 64'd0;
    m_axi_rid = 13'd0; m_axi_rresp = OKAY;
    forever begin
      @(negedge clk);
      ar_hs = m_axi_arvalid && m_axi_arready;
      r_hs  = m_axi_rvalid && m_axi_rready;
      if (ar_hs) begin
        base = m_axi_araddr; len = m_axi_arlen; id = m_axi_arid;
      end
      @(posedge clk); #1;
      if (reset) begin
        m_axi_rvalid = 1'b0; m_axi_rlast = 1'b0;
      end else if (ar_hs || (r_hs && !m_axi_rlast)) begin
        beat = ar_hs ? 8'd0 : beat + 8'd1;
        m_axi_rvalid = 1'b1;
        m_axi_rdata = base + 64'(beat);
        m_axi_rid = id;
        m_axi_rresp = slv_resp;
        m_axi_rlast = (beat == len);
      end else if (r_hs) begin
        m_axi_rvalid = 1'b0; m_axi_rlast = 1'b0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    s0_arid = 13'd0; s0_araddr = 64'd0; s0_arlen = 8'd0; s0_arsize = 3'd3; s0_arburst = BURST_INCR;
    s1_arid = 13'd0; s1_araddr = 64'd0; s1_arlen = 8'd0; s1_arsize = 3'd3; s1_arburst = BURST_WRAP;
    s0_arvalid = 1'b1; s1_arvalid = 1'b1; s0_rready = 1'b1; s1_rready = 1'b1;

    // Reset: requests pending, yet every handshake output stays low.
    @(negedge clk);
    chk_quiet("rst");
    s0_arvalid = 1'b0; s1_arvalid = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // T1: s0 alone, 8 beats, one-cycle request latency.
    expect_txn(1'b0, 64'h1000, 8'd7, 13'h011, BURST_INCR, OKAY);
    fork
      issue(0, 64'h1000, 8'd7, 13'h011);
      begin
        @(negedge clk); chk("t1_arvalid_early", 64'(m_axi_arvalid), 64'd0);
        @(negedge clk); chk("t1_arvalid_n1", 64'(m_axi_arvalid), 64'd1);
      end
    join
    rxb += 8; wait_rx(rxb);
    @(posedge clk); #1;
    @(negedge clk); chk("t1_idle_rready", 64'(m_axi_rready), 64'd0);
    @(posedge clk); #1;

    // T2: tie straight after reset -> s0 first, s1 two cycles after s0's rlast.
    reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    expect_txn(1'b0, 64'h2000, 8'd3, 13'h020, BURST_INCR, OKAY);
    expect_txn(1'b1, 64'h3000, 8'd3, 13'h031, BURST_WRAP, OKAY);
    fork
      issue(0, 64'h2000, 8'd3, 13'h020);
      issue(1, 64'h3000, 8'd3, 13'h031);
    join
    chk("t2_gap", 64'(last_gap), 64'd2);
    rxb += 8; wait_rx(rxb);
    repeat (2) begin @(posedge clk); #1; end

    // T2b: after an s0 burst prio points at s1, so s1 wins the tie.
    expect_txn(1'b0, 64'h4000, 8'd1, 13'h040, BURST_INCR, OKAY);
    issue(0, 64'h4000, 8'd1, 13'h040);
    rxb += 2; wait_rx(rxb);
    repeat (2) begin @(posedge clk); #1; end
    expect_txn(1'b1, 64'h5000, 8'd2, 13'h051, BURST_WRAP, OKAY);
    expect_txn(1'b0, 64'h6000, 8'd2, 13'h060, BURST_INCR, OKAY);
    fork
      issue(0, 64'h6000, 8'd2, 13'h060);
      issue(1, 64'h5000, 8'd2, 13'h051);
    join
    rxb += 6; wait_rx(rxb);
    repeat (2) begin @(posedge clk); #1; end

    // T3: s1 back-pressures three cycles mid-burst.
    expect_txn(1'b1, 64'h7000, 8'd5, 13'h071, BURST_WRAP, OKAY);
    issue(1, 64'h7000, 8'd5, 13'h071);
    wait_rx(rxb + 2);
    @(posedge clk); #1 s1_rready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t3_m_rready_low", 64'(m_axi_rready), 64'd0);
      chk("t3_s1_rvalid_held", 64'(s1_rvalid), 64'd1);
    end
    @(posedge clk); #1 s1_rready = 1'b1;
    rxb += 6; wait_rx(rxb);
    repeat (2) begin @(posedge clk); #1; end

    // T4: single-beat read with SLVERR closes on the first beat.
    slv_resp = SLVERR;
    expect_txn(1'b0, 64'h8000, 8'd0, 13'h080, BURST_INCR, SLVERR);
    issue(0, 64'h8000, 8'd0, 13'h080);
    rxb += 1; wait_rx(rxb);
    slv_resp = OKAY;
    @(posedge clk); #1;
    @(negedge clk); chk("t4_idle_rready", 64'(m_axi_rready), 64'd0);
    @(posedge clk); #1;

    // T5: reset during beat 3 of 8 abandons the burst and clears prio.
    expect_txn(1'b0, 64'h9000, 8'd7, 13'h090, BURST_INCR, OKAY);
    issue(0, 64'h9000, 8'd7, 13'h090);
    wait_rx(rxb + 2);
    @(posedge clk); #1 reset = 1'b1;
    @(negedge clk);
    chk_quiet("t5_rst");
    r_q.delete();
    rxb += 2;
    chk("t5_beats_before_reset", 64'(rx_cnt), 64'(rxb));
    @(posedge clk); #1;
    @(posedge clk); #1 reset = 1'b0;
    @(posedge clk); #1;
    expect_txn(1'b0, 64'hA000, 8'd1, 13'h0A0, BURST_INCR, OKAY);
    expect_txn(1'b1, 64'hB000, 8'd1, 13'h0B1, BURST_WRAP, OKAY);
    fork
      issue(0, 64'hA000, 8'd1, 13'h0A0);
      issue(1, 64'hB000, 8'd1, 13'h0B1);
    join
    rxb += 4; wait_rx(rxb);
    repeat (2) begin @(posedge clk); #1; end

    chk("ar_q_drained", 64'(ar_q.size()), 64'd0);
    chk("r_q_drained", 64'(r_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
